// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// The optional per-producer beat counters are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int STAT_W = 16;

  function automatic int beat_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any_valid
);

  always_comb begin
    int  idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx] && !found) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any_valid = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_STATS_EN to add the saturating per-producer stat_beats counters.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       grant,
  input  logic                     fifo_full,
  output logic                     fifo_w_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic [0:0]               state
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_beats
`endif
);

  localparam int CNT_W = beat_cnt_width(MAX_BURST);
  localparam int PTR_W = $clog2(NUM_REQ);

  // Handshake: a beat transfers on a rising edge where req_valid[o] and
  // req_ready[o] are both high; req_ready only rises for the granted owner
  // and only while fifo_full is low, so fifo_w_en mirrors the transfer.
  logic [0:0]         state_q;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   beat_cnt;
  logic [NUM_REQ-1:0] pick;
  logic               any_valid;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   next_rr;
  logic               owner_valid;
  logic               accept;
  logic               last_beat;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .pick     (pick),
    .any_valid(any_valid)
  );

  // grant is zero in IDLE, so the data mux naturally drives 0 there.
  always_comb begin
    owner        = '0;
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        owner        = PTR_W'(i);
        fifo_data_in = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign owner_valid = |(grant & req_valid);
  assign accept      = (state_q == ST_GRANT) && owner_valid && !fifo_full;
  assign req_ready   = accept ? grant : '0;
  assign fifo_w_en   = accept;
  assign last_beat   = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign next_rr     = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign state       = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (state_q == ST_IDLE) begin
      if (any_valid) begin
        grant    <= pick;
        beat_cnt <= '0;
        state_q  <= ST_GRANT;
      end
    end else begin
      // A full-stall with valid held keeps the grant and the count unchanged.
      if ((accept && last_beat) || !owner_valid) begin
        state_q <= ST_IDLE;
        grant   <= '0;
        rr_ptr  <= next_rr;
      end else if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_beats <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && (stat_beats[i*STAT_W +: STAT_W] != {STAT_W{1'b1}}))
          stat_beats[i*STAT_W +: STAT_W] <= stat_beats[i*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter with a cycle-level reference model.
// Build with FIFO_ARB_STATS_EN defined to also exercise stat_beats.
module tb_fifo_write_arbiter;

  localparam int WIDTH     = 8;
  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;
  localparam int STAT_W    = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*WIDTH-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       grant;
  logic                     fifo_full = 1'b0;
  logic                     fifo_w_en;
  logic [WIDTH-1:0]         fifo_data_in;
  logic [0:0]               state;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*STAT_W-1:0] stat_beats;
`endif

  fifo_write_arbiter #(
    .WIDTH    (WIDTH),
    .NUM_REQ  (NUM_REQ),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .grant       (grant),
    .fifo_full   (fifo_full),
    .fifo_w_en   (fifo_w_en),
    .fifo_data_in(fifo_data_in),
    .state       (state)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_beats  (stat_beats)
`endif
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // producer driver state: each producer sends `remaining` beats counting up from next_val
  int         remaining[NUM_REQ];
  logic [7:0] next_val[NUM_REQ];

  task automatic apply_inputs();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = (remaining[i] > 0);
      req_data[i*WIDTH +: WIDTH] = next_val[i];
    end
  endtask

  task automatic start_producer(input int idx, input int beats, input logic [7:0] first);
    remaining[idx] = beats;
    next_val[idx]  = first;
    apply_inputs();
  endtask

  initial begin
    logic [NUM_REQ-1:0] acc_s;
    for (int i = 0; i < NUM_REQ; i++) begin
      remaining[i] = 0;
      next_val[i]  = '0;
    end
    forever begin
      @(negedge clk);
      acc_s = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_s[i]) begin
          next_val[i]  = next_val[i] + 8'd1;
          remaining[i] = remaining[i] - 1;
        end
      end
      apply_inputs();
    end
  end

  // scoreboard and logs
  logic [WIDTH-1:0] exp_q[$];
  int grant_seq[$];
  int sess_beats[$];
  int wr_cnt = 0;

  // reference model: owner index (-1 when nobody holds the port), beats in burst, rr pointer
  int m_owner = -1;
  int m_beats = 0;
  int m_rr    = 0;
  int m_stat[NUM_REQ];

  task automatic model_release();
    m_rr    = (m_owner + 1) % NUM_REQ;
    m_owner = -1;
  endtask

  initial begin
    logic               acc;
    logic [NUM_REQ-1:0] exp_grant;
    logic [NUM_REQ-1:0] exp_ready;
    logic [WIDTH-1:0]   exp_data;
    logic [NUM_REQ-1:0] prev_grant;
    int                 idx;
    prev_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) m_stat[i] = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_owner = -1;
        m_beats = 0;
        m_rr    = 0;
        for (int i = 0; i < NUM_REQ; i++) m_stat[i] = 0;
      end
      exp_grant = (m_owner < 0) ? '0 : (NUM_REQ'(1) << m_owner);
      acc       = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
      exp_ready = acc ? exp_grant : '0;
      exp_data  = (m_owner >= 0) ? req_data[m_owner*WIDTH +: WIDTH] : '0;
      check("grant", grant, exp_grant);
      check("req_ready", req_ready, exp_ready);
      check("fifo_w_en", fifo_w_en, acc);
      check("fifo_data_in", fifo_data_in, exp_data);
      check("state", state, (m_owner >= 0));
`ifdef FIFO_ARB_STATS_EN
      begin
        logic [NUM_REQ*STAT_W-1:0] exp_stat;
        for (int i = 0; i < NUM_REQ; i++) exp_stat[i*STAT_W +: STAT_W] = STAT_W'(m_stat[i]);
        check("stat_beats", stat_beats, exp_stat);
      end
`endif
      // logs and scoreboard from DUT behaviour
      if (grant != prev_grant && grant != '0) begin
        for (int i = 0; i < NUM_REQ; i++) if (grant[i]) grant_seq.push_back(i);
        sess_beats.push_back(0);
      end
      prev_grant = grant;
      if (fifo_w_en) begin
        wr_cnt++;
        if (sess_beats.size() > 0) sess_beats[sess_beats.size()-1]++;
        if (exp_q.size() == 0) check("sb_extra_write", fifo_data_in, '0 - 1);
        else check("sb_data", fifo_data_in, exp_q.pop_front());
      end
      // advance model to the state after the coming rising edge
      if (acc && m_stat[m_owner] < 65535) m_stat[m_owner]++;
      if (reset) begin
        // stays in reset
      end else if (m_owner < 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_rr + k) % NUM_REQ;
          if (req_valid[idx] && m_owner < 0) begin
            m_owner = idx;
            m_beats = 0;
          end
        end
      end else if (acc) begin
        m_beats++;
        if (m_beats == MAX_BURST) model_release();
      end else if (!req_valid[m_owner]) begin
        model_release();
      end
    end
  end

  task automatic push_exp(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + 8'(i));
  endtask

  task automatic clear_logs();
    exp_q.delete();
    grant_seq.delete();
    sess_beats.delete();
    wr_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
    apply_inputs();
    repeat (2) @(posedge clk);
    #2;
    clear_logs();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    bit done;
    int left;
    n    = 0;
    done = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      left = 0;
      for (int i = 0; i < NUM_REQ; i++) left += remaining[i];
      done = (left == 0) && (grant == '0);
    end
    check({name, "_done"}, done, 1);
    repeat (2) @(negedge clk);
    check({name, "_sb_missing"}, exp_q.size(), 0);
  endtask

  task automatic check_log(input string name, input int exp_seq[$], input int exp_beats[$]);
    check({name, "_nseq"}, grant_seq.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < grant_seq.size(); i++)
      check($sformatf("%s_seq%0d", name, i), grant_seq[i], exp_seq[i]);
    check({name, "_nsess"}, sess_beats.size(), exp_beats.size());
    for (int i = 0; i < exp_beats.size() && i < sess_beats.size(); i++)
      check($sformatf("%s_beats%0d", name, i), sess_beats[i], exp_beats[i]);
  endtask

  initial begin
    int n;
    // reset values
    #3;
    check("rst_grant", grant, 4'b0000);
    check("rst_w_en", fifo_w_en, 1'b0);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_data", fifo_data_in, 8'h00);
    check("rst_state", state, 1'b0);
    do_reset();

    // single producer, 6 beats A0..A5
    push_exp(8'hA0, 6);
    @(posedge clk);
    #2;
    start_producer(1, 6, 8'hA0);
    @(negedge clk);
    check("t1_idle_before", grant, 4'b0000);
    @(negedge clk);
    check("t1_grant_latency", grant, 4'b0010);
    check("t1_first_w_en", fifo_w_en, 1'b1);
    wait_done("t1");
    check_log("t1", '{1, 1}, '{4, 2});

    // round robin, all four streaming with distinct tags
    do_reset();
    push_exp(8'h10, 4); push_exp(8'h20, 4); push_exp(8'h30, 4); push_exp(8'h40, 4);
    push_exp(8'h14, 4);
    @(posedge clk);
    #2;
    start_producer(0, 8, 8'h10);
    start_producer(1, 4, 8'h20);
    start_producer(2, 4, 8'h30);
    start_producer(3, 4, 8'h40);
    wait_done("t2");
    check_log("t2", '{0, 1, 2, 3, 0}, '{4, 4, 4, 4, 4});

    // full stall after two beats
    do_reset();
    push_exp(8'h80, 6);
    @(posedge clk);
    #2;
    start_producer(0, 6, 8'h80);
    n = 0;
    while (wr_cnt < 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("t3_reach_two", (wr_cnt >= 2), 1'b1);
    #2;
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall_w_en", fifo_w_en, 1'b0);
      check("t3_stall_ready", req_ready, 4'b0000);
      check("t3_stall_grant", grant, 4'b0001);
    end
    @(posedge clk);
    #2;
    fifo_full = 1'b0;
    wait_done("t3");
    check_log("t3", '{0, 0}, '{4, 2});

    // early release: producer 2 drops after one beat, producer 3 then wins over 0
    do_reset();
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h98);
    exp_q.push_back(8'h99);
    exp_q.push_back(8'h9F);
    @(posedge clk);
    #2;
    start_producer(2, 1, 8'h90);
    start_producer(3, 2, 8'h98);
    n = 0;
    while (grant != 4'b0100 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_grant2", grant, 4'b0100);
    @(posedge clk);
    #2;
    start_producer(0, 1, 8'h9F);
    @(negedge clk);
    check("t4_dropped_w_en", fifo_w_en, 1'b0);
    check("t4_dropped_grant", grant, 4'b0100);
    @(negedge clk);
    check("t4_idle_state", state, 1'b0);
    check("t4_idle_grant", grant, 4'b0000);
    @(negedge clk);
    check("t4_next_grant3", grant, 4'b1000);
    wait_done("t4");
    check_log("t4", '{2, 3, 0}, '{1, 2, 1});

    // reset mid-burst
    do_reset();
    push_exp(8'h50, 5);
    exp_q.push_back(8'h60);
    exp_q.push_back(8'h61);
    @(posedge clk);
    #2;
    start_producer(0, 5, 8'h50);
    n = 0;
    while (grant != 4'b0001 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_grant0", grant, 4'b0001);
    @(posedge clk);
    #2;
    reset = 1'b1;
    start_producer(1, 2, 8'h60);
    #1;
    check("t5_rst_grant", grant, 4'b0000);
    check("t5_rst_w_en", fifo_w_en, 1'b0);
    check("t5_rst_state", state, 1'b0);
`ifdef FIFO_ARB_STATS_EN
    check("t5_rst_stats", stat_beats, 64'h0);
`endif
    @(posedge clk);
    #2;
    reset = 1'b0;
    n = 0;
    while (grant == 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_first_after_rst", grant, 4'b0001);
    wait_done("t5");
    check_log("t5", '{0, 0, 1}, '{1, 4, 2});

`ifdef FIFO_ARB_STATS_EN
    // stats: five beats from producer 3
    do_reset();
    push_exp(8'h70, 5);
    @(posedge clk);
    #2;
    start_producer(3, 5, 8'h70);
    wait_done("t6");
    check("t6_stats", stat_beats, 64'h0005_0000_0000_0000);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-port arbiter that lets NUM_REQ producers share the single write port of the team's synchronous FIFO. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST beats and drives the FIFO's w_en/data_in, never writing while the FIFO reports full. It sits directly in front of the FIFO; the FIFO read side is untouched.

## Interface
- WIDTH, 8: data width, must match the FIFO WIDTH.
- NUM_REQ, 4: number of producers, ≥2.
- MAX_BURST, 4: maximum beats per grant, ≥1.
- clk  in  1  clock. One clock domain; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-producer data valid.
- req_data  in  NUM_REQ*WIDTH  producer i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  per-producer beat accepted this cycle.
- grant  out  NUM_REQ  one-hot current owner, registered.
- fifo_full  in  1  FIFO full flag.
- fifo_w_en  out  1  FIFO write enable.
- fifo_data_in  out  WIDTH  FIFO write data.
- stat_beats  out  NUM_REQ*16  per-producer beat counters; present only with FIFO_ARB_STATS_EN.

## Operation
- States: IDLE, GRANT.
- **IDLE**
  - grant=0.
  - If any req_valid is set, pick the first valid requester searching from rr_ptr upward with wrap.
  - Register the one-hot grant, clear beat_cnt, go to GRANT.
- **GRANT**, owner o
  - A beat is accepted when req_valid[o] && !fifo_full.
  - req_ready[o] = fifo_w_en = beat accepted. Combinational from registered grant and inputs.
  - fifo_data_in = req_data[o] whenever in GRANT, and 0 in IDLE.
  - An accepted beat increments beat_cnt, which is $clog2(MAX_BURST+1) bits wide.
- **Release** to IDLE, with grant cleared, when either:
  - the beat accepted brings beat_cnt to MAX_BURST; or
  - req_valid[o] is low, so the producer dropped valid.
- On release, rr_ptr = (o+1) mod NUM_REQ.
- Full stall: while fifo_full, no beat is accepted, beat_cnt holds, and the grant is held. A stall does not count toward MAX_BURST and there is no timeout.
- req_ready is never asserted for a non-owner. fifo_w_en is never asserted while fifo_full is high.

## Timing
- Reset values:
  - state=IDLE, grant=0, rr_ptr=0 (requester 0 has top priority first), beat_cnt=0.
  - req_ready=0, fifo_w_en=0, fifo_data_in=0, stat_beats=0.
- Arbitration latency:
  - req_valid seen in IDLE at edge k gives grant at edge k+1.
  - The first beat is written at edge k+2.
- Bursts are back-to-back at one beat per cycle while fifo_full is low.
- Exactly one IDLE cycle separates consecutive grants.
- A single requester streaming continuously gets MAX_BURST beats, one idle cycle, then is regranted.
- Reset mid-burst: state returns to IDLE immediately. A beat coinciding with reset assertion is not guaranteed written.
- Simultaneous requests are resolved by rr_ptr order only.

## Configuration
- **FIFO_ARB_STATS_EN defined:**
  - The stat_beats port exists.
  - Counter i increments on each beat accepted from producer i and saturates at 16'hFFFF.
  - Counters are cleared only by reset.
- **Not defined:** the port and the counters are absent. Arbitration behaviour is identical either way.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum typedef (IDLE, GRANT);
  - STAT_W = 16;
  - a function computing beat_cnt width.
- Sub-module rr_pick:
  - combinational;
  - inputs: NUM_REQ request vector and rr_ptr;
  - outputs: one-hot pick plus an any-valid flag.
- Instantiated once in the top block.

## Test plan
- **Single producer:** req 1 valid with 8'hA0..8'hA5 (6 beats), FIFO empty, MAX_BURST=4.
  - Required: grant=4'b0010 one cycle after valid.
  - Required: 4 writes, one idle cycle, regrant, 2 writes.
  - Required: FIFO reads back A0..A5 in order.
- **Round-robin:** all four producers continuously valid, each with a distinct tag.
  - Required: grant order 0,1,2,3,0.
  - Required: each grant writes exactly 4 beats.
- **Full stall:** fifo_full forced high for 3 cycles mid-burst after 2 beats.
  - Required: fifo_w_en=0 and req_ready=0 during the stall.
  - Required: grant held, then exactly 2 more beats, then release.
- **Early release:** producer 2 drops valid after 1 beat.
  - Required: IDLE next cycle.
  - Required: rr_ptr=3, so a pending producer 3 wins over producer 0.
- **Reset mid-burst:** assert reset while grant=4'b0001.
  - Required: grant=0, fifo_w_en=0 and stat_beats=0 immediately.
  - Required: after release, requester 0 is granted first.
- **Stats (FIFO_ARB_STATS_EN):** write 5 beats from producer 3.
  - Required: stat_beats[3*16 +: 16]=5 and all other counters 0.
